// File: rtl/key_step_debouncer.sv
// key_step_debouncer
// Conditions the raw step push-button and serial-input switch for the
// sequence-detector FSMs. Both inputs pass through a 2-FF synchroniser. The
// button is then debounced by a 4-state FSM that issues one single-cycle step
// pulse per accepted press. The pulse is accompanied by the synchronised w
// sample and a wrap-around step count.
module key_step_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             key_n,
  input  logic             w_raw,
  output logic             step,
  output logic             w_out,
  output logic             held,
  output logic [CNT_W-1:0] step_count
);

  // Counter is wide enough to hold DEBOUNCE_CYCLES, but it only ever reaches
  // DEBOUNCE_CYCLES-1 before the FSM leaves the check state.
  localparam int DC_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [DC_W-1:0] CNT_MAX = DC_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DC_W-1:0] CNT_ONE = DC_W'(1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK = 2'd1;
  localparam logic [1:0] ST_HELD      = 2'd2;
  localparam logic [1:0] ST_REL_CHK   = 2'd3;

  logic            key_meta_r;
  logic            key_sync_r;
  logic            w_meta_r;
  logic            w_sync_r;
  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [DC_W-1:0] cnt_r;
  logic [DC_W-1:0] cnt_inc_s;
  logic [DC_W-1:0] cnt_nxt_s;
  logic            press_s;
  logic            accept_s;
  logic            held_nxt_s;

  // Two-stage synchronisers. The key chain resets to "released" (high).
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      key_meta_r <= 1'b1;
      key_sync_r <= 1'b1;
      w_meta_r   <= 1'b0;
      w_sync_r   <= 1'b0;
    end else begin
      key_meta_r <= key_n;
      key_sync_r <= key_meta_r;
      w_meta_r   <= w_raw;
      w_sync_r   <= w_meta_r;
    end
  end

  // Debounce FSM next-state logic; accept_s marks the single accepting edge.
  always_comb begin
    press_s     = ~key_sync_r;
    state_nxt_s = state_r;
    cnt_inc_s   = cnt_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (press_s) begin
          state_nxt_s = ST_PRESS_CHK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRESS_CHK: begin
        if (!press_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == CNT_MAX) begin
          state_nxt_s = ST_HELD;
          accept_s    = 1'b1;
        end else begin
          cnt_inc_s   = cnt_r + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!press_s) begin
          state_nxt_s = ST_REL_CHK;
        end else begin
          state_nxt_s = ST_HELD;
        end
      end
      ST_REL_CHK: begin
        if (press_s) begin
          state_nxt_s = ST_HELD;
        end else if (cnt_r == CNT_MAX) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_inc_s   = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
    // Any state change restarts the stability count.
    cnt_nxt_s  = (state_nxt_s != state_r) ? {DC_W{1'b0}} : cnt_inc_s;
    held_nxt_s = (state_nxt_s == ST_HELD) || (state_nxt_s == ST_REL_CHK);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {DC_W{1'b0}};
      step       <= 1'b0;
      held       <= 1'b0;
      w_out      <= 1'b0;
      step_count <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      step    <= accept_s;
      held    <= held_nxt_s;
      if (accept_s) begin
        w_out      <= w_sync_r;
        step_count <= step_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_key_step_debouncer.sv
// Directed bench for key_step_debouncer with DEBOUNCE_CYCLES=4 and CNT_W=4.
// Inputs change just after a falling edge and are sampled at the next rising
// edge, which is "posedge #1" after the drive. Outputs are checked on the
// following falling edge. With D=4, a clean press yields step after posedge #7.
module tb_key_step_debouncer;
  localparam int D  = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          Reset;
  logic          key_n;
  logic          w_raw;
  logic          step;
  logic          w_out;
  logic          held;
  logic [CW-1:0] step_count;

  int checks   = 0;
  int failures = 0;

  key_step_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_W(CW)) dut (
    .clk(clk), .Reset(Reset), .key_n(key_n), .w_raw(w_raw),
    .step(step), .w_out(w_out), .held(held), .step_count(step_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          key_n;
    logic          w_raw;
    logic          step;
    logic          held;
    logic          w_out;
    logic [CW-1:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic k, input logic w, input logic s,
                     input logic h, input logic wo, input logic [CW-1:0] c);
    vec_t v;
    v.key_n = k; v.w_raw = w; v.step = s; v.held = h; v.w_out = wo; v.cnt = c;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n, inout int steps);
    for (int i = 0; i < n; i++) begin
      tick();
      if (step === 1'b1) steps++;
    end
  endtask

  task automatic press_once(input logic w, input logic [CW-1:0] exp_cnt, input int idx);
    int s;
    s = 0;
    key_n = 1'b0; w_raw = w;
    run(10, s);
    key_n = 1'b1;
    run(10, s);
    chk($sformatf("press%0d steps", idx), s, 1);
    chk($sformatf("press%0d w_out", idx), w_out, w);
    chk($sformatf("press%0d count", idx), step_count, exp_cnt);
  endtask

  initial begin
    int s;
    // Test 1 idle after reset; test 2 clean press and release;
    // test 3 bounce rejection followed by a long press and release.
    add(20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(6,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1,  1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd1);
    add(5,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1);
    add(6,  1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1);
    add(4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    add(3,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    add(1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    add(2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    add(6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    add(6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
    add(1,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2);
    add(3,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
    add(6,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2);
    add(4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);

    Reset = 1'b1; key_n = 1'b1; w_raw = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset step", step, 1'b0);
    chk("reset held", held, 1'b0);
    chk("reset w_out", w_out, 1'b0);
    chk("reset count", step_count, 4'd0);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      key_n = vecs[i].key_n;
      w_raw = vecs[i].w_raw;
      tick();
      chk($sformatf("vec%0d step", i), step, vecs[i].step);
      chk($sformatf("vec%0d held", i), held, vecs[i].held);
      chk($sformatf("vec%0d w_out", i), w_out, vecs[i].w_out);
      chk($sformatf("vec%0d count", i), step_count, vecs[i].cnt);
    end

    // Test 4: long hold, bouncy release, then a final settle.
    s = 0;
    key_n = 1'b0; w_raw = 1'b1;
    run(1000, s);
    key_n = 1'b1; run(2, s);
    key_n = 1'b0; run(2, s);
    key_n = 1'b1; run(2, s);
    key_n = 1'b0; run(2, s);
    chk("hold bounce held", held, 1'b1);
    key_n = 1'b1;
    run(6, s);
    chk("release held before 7", held, 1'b1);
    run(1, s);
    chk("release held at 7", held, 1'b0);
    chk("hold steps", s, 1);
    chk("hold count", step_count, 4'd3);
    chk("hold w_out", w_out, 1'b1);

    // w_raw set before posedge #5 is seen by the accepting edge (#7).
    s = 0;
    key_n = 1'b0; w_raw = 1'b0;
    run(4, s);
    w_raw = 1'b1;
    run(3, s);
    chk("wlate1 step", step, 1'b1);
    chk("wlate1 w_out", w_out, 1'b1);
    chk("wlate1 count", step_count, 4'd4);
    key_n = 1'b1; run(10, s);

    // w_raw set before posedge #6 is too late; the older value is taken.
    key_n = 1'b0; w_raw = 1'b0;
    run(5, s);
    w_raw = 1'b1;
    run(2, s);
    chk("wlate2 step", step, 1'b1);
    chk("wlate2 w_out", w_out, 1'b0);
    chk("wlate2 count", step_count, 4'd5);
    key_n = 1'b1; run(10, s);
    chk("wlate steps", s, 2);

    // Test 5: 17 presses from a fresh reset; the count wraps after 15.
    Reset = 1'b1;
    tick();
    chk("reset2 count", step_count, 4'd0);
    Reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      press_once(((i % 2) == 0) ? 1'b1 : 1'b0, CW'((i + 1) % 16), i);
    end

    // Test 6: reset during HELD while the button stays pressed.
    s = 0;
    key_n = 1'b0; w_raw = 1'b1;
    run(10, s);
    chk("pre-reset held", held, 1'b1);
    #2 Reset = 1'b1;
    #1;
    chk("midreset step", step, 1'b0);
    chk("midreset held", held, 1'b0);
    chk("midreset w_out", w_out, 1'b0);
    chk("midreset count", step_count, 4'd0);
    @(negedge clk);
    Reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk($sformatf("postreset step c%0d", i), step, 1'b0);
    end
    tick();
    chk("postreset step c7", step, 1'b1);
    chk("postreset held", held, 1'b1);
    chk("postreset count", step_count, 4'd1);
    chk("postreset w_out", w_out, 1'b1);
    tick();
    chk("postreset step c8", step, 1'b0);
    key_n = 1'b1;
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
